// File: rtl/phrase_seq_pkg.sv
// Shared types and constants for the phrase sequencer slice.
package phrase_seq_pkg;

    typedef enum logic [0:0] {IDLE, PLAY} seq_state_e;

    localparam int unsigned ROWS = 16;

    // Channel word layout: {note, volume, instrument}
    localparam int unsigned NOTE_MSB = 15;
    localparam int unsigned NOTE_LSB = 8;
    localparam int unsigned VOL_MSB  = 7;
    localparam int unsigned VOL_LSB  = 2;
    localparam int unsigned INST_MSB = 1;
    localparam int unsigned INST_LSB = 0;

    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [3:0] LAST_ROW  = 4'd15;

    function automatic logic [7:0] note_of(input logic [15:0] word);
        return word[NOTE_MSB:NOTE_LSB];
    endfunction

endpackage

// File: rtl/phrase_sequencer_if.sv
// Control, phrase-store and trigger signals of the phrase sequencer.
interface phrase_sequencer_if #(
    parameter int unsigned TICK_W  = 24,
    parameter int unsigned SPEED_W = 5
);
    logic               play;
    logic               stop;
    logic               loop_en;
    logic [3:0]         start_row;
    logic [TICK_W-1:0]  tick_period;
    logic [SPEED_W-1:0] ticks_per_row;
    logic [3:0]         mute;
    logic [3:0]         row;
    logic [15:0]        channel_0;
    logic [15:0]        channel_1;
    logic [15:0]        channel_2;
    logic [15:0]        channel_3;
    logic [15:0]        ch0_q;
    logic [15:0]        ch1_q;
    logic [15:0]        ch2_q;
    logic [15:0]        ch3_q;
    logic               note_valid;
    logic [3:0]         ch_trig;
    logic               playing;
    logic               phrase_end;

    // Environment side: control registers and phrase store.
    modport master (
        output play, stop, loop_en, start_row, tick_period, ticks_per_row, mute,
        output channel_0, channel_1, channel_2, channel_3,
        input  row, ch0_q, ch1_q, ch2_q, ch3_q, note_valid, ch_trig, playing, phrase_end
    );

    // Sequencer side.
    modport slave (
        input  play, stop, loop_en, start_row, tick_period, ticks_per_row, mute,
        input  channel_0, channel_1, channel_2, channel_3,
        output row, ch0_q, ch1_q, ch2_q, ch3_q, note_valid, ch_trig, playing, phrase_end
    );

endinterface

// File: rtl/seq_tick_div.sv
// Tempo divider: one tick every max(tick_period,1) enabled clocks.
module seq_tick_div #(
    parameter int unsigned TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [TICK_W-1:0] tick_period,
    output logic              tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d, period_m1;

    // >= compare so a period lowered mid-count fires at once instead of wrapping.
    always_comb begin
        period_m1 = (tick_period == '0) ? '0 : tick_period - TICK_W'(1);
        tick      = en & (cnt_q >= period_m1);
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + TICK_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phrase_sequencer.sv
// Phrase playback controller: row stepping at a programmable tempo,
// channel word capture and per-channel note triggers.
module phrase_sequencer
    import phrase_seq_pkg::*;
#(
    parameter int unsigned TICK_W  = 24,
    parameter int unsigned SPEED_W = 5
) (
    input logic               clk,
    input logic               rst_active_high,
    phrase_sequencer_if.slave bus
);

    seq_state_e         state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [SPEED_W-1:0] spd_q, spd_d, spd_m1;
    logic               fetch_q, fetch_d;
    logic [15:0]        chq_q [4];
    logic [15:0]        chan [4];
    logic               note_valid_q;
    logic [3:0]         trig_q, trig_d;
    logic               phrase_end_q, phrase_end_d;
    logic               tick, div_clr, capture;

    seq_tick_div #(
        .TICK_W (TICK_W)
    ) u_tick_div (
        .clk         (clk),
        .rst         (rst_active_high),
        .en          (state_q == PLAY),
        .clr         (div_clr),
        .tick_period (bus.tick_period),
        .tick        (tick)
    );

    // Next state, row stepping and trigger decode; stop beats play beats tick.
    always_comb begin
        chan[0] = bus.channel_0;
        chan[1] = bus.channel_1;
        chan[2] = bus.channel_2;
        chan[3] = bus.channel_3;
        state_d      = state_q;
        row_d        = row_q;
        spd_d        = spd_q;
        fetch_d      = 1'b0;
        phrase_end_d = 1'b0;
        div_clr      = 1'b0;
        spd_m1  = (bus.ticks_per_row == '0) ? '0 : bus.ticks_per_row - SPEED_W'(1);
        // A stop in the fetch cycle cancels the capture.
        capture = fetch_q & ~bus.stop;
        for (int i = 0; i < 4; i++) begin
            trig_d[i] = capture & ~bus.mute[i] & (note_of(chan[i]) != NOTE_REST);
        end
        if (bus.stop) begin
            state_d = IDLE;
            spd_d   = '0;
            div_clr = 1'b1;
        end else if (bus.play) begin
            state_d = PLAY;
            row_d   = bus.start_row;
            spd_d   = '0;
            fetch_d = 1'b1;
            div_clr = 1'b1;
        end else if (state_q == PLAY && tick) begin
            if (spd_q >= spd_m1) begin
                spd_d = '0;
                if (row_q == LAST_ROW) begin
                    phrase_end_d = 1'b1;
                    if (bus.loop_en) begin
                        row_d   = 4'd0;
                        fetch_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        div_clr = 1'b1;
                    end
                end else begin
                    row_d   = row_q + 4'd1;
                    fetch_d = 1'b1;
                end
            end else begin
                spd_d = spd_q + SPEED_W'(1);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q      <= IDLE;
            row_q        <= '0;
            spd_q        <= '0;
            fetch_q      <= 1'b0;
            note_valid_q <= 1'b0;
            trig_q       <= '0;
            phrase_end_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                chq_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            spd_q        <= spd_d;
            fetch_q      <= fetch_d;
            note_valid_q <= capture;
            trig_q       <= trig_d;
            phrase_end_q <= phrase_end_d;
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    chq_q[i] <= chan[i];
                end
            end
        end
    end

    assign bus.row        = row_q;
    assign bus.ch0_q      = chq_q[0];
    assign bus.ch1_q      = chq_q[1];
    assign bus.ch2_q      = chq_q[2];
    assign bus.ch3_q      = chq_q[3];
    assign bus.note_valid = note_valid_q;
    assign bus.ch_trig    = trig_q;
    assign bus.playing    = (state_q == PLAY);
    assign bus.phrase_end = phrase_end_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Scoreboard bench for phrase_sequencer: expected note events and phrase ends
// are queued when playback is started and compared as the DUT emits them.
module tb_phrase_sequencer;
    import phrase_seq_pkg::*;

    typedef struct {
        int          cyc;
        logic [63:0] w;
        logic [3:0]  trig;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  nq[$];
    int   pq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phrase_sequencer_if bus ();

    phrase_sequencer dut (
        .clk             (clk),
        .rst_active_high (rst),
        .bus             (bus)
    );

    // Phrase store contents; row 5 holds the rest/mute scenario.
    function automatic logic [15:0] word(input int r, input int k);
        logic [7:0] n;
        if (r == 5 && k == 1) n = 8'h00;
        else if (r == 5 && k == 2) n = 8'h3C;
        else if ((r + k) % 7 == 3) n = 8'h00;
        else n = 8'h20 + 8'(r * 4 + k);
        return {n, 6'(r * 3 + k), 2'(k)};
    endfunction

    function automatic logic [63:0] words(input int r);
        return {word(r, 3), word(r, 2), word(r, 1), word(r, 0)};
    endfunction

    function automatic logic [3:0] trigs(input int r, input logic [3:0] m);
        logic [3:0]  t;
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            w    = word(r, k);
            t[k] = ~m[k] & (w[15:8] != 8'h00);
        end
        return t;
    endfunction

    assign bus.channel_0 = word(int'(bus.row), 0);
    assign bus.channel_1 = word(int'(bus.row), 1);
    assign bus.channel_2 = word(int'(bus.row), 2);
    assign bus.channel_3 = word(int'(bus.row), 3);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_note(input int c, input int r);
        ev_t e;
        e.cyc  = c;
        e.w    = words(r);
        e.trig = trigs(r, bus.mute);
        nq.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives a one-cycle play at the current negedge; returns the play cycle.
    task automatic start_play(input logic [3:0] sr, input int per, input int tpr,
                              input logic lp, output int p);
        p                 = cyc;
        bus.start_row     = sr;
        bus.tick_period   = 24'(per);
        bus.ticks_per_row = 5'(tpr);
        bus.loop_en       = lp;
        bus.play          = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic drain(input string tag);
        chk({tag, "_notes_left"}, 64'(nq.size()), 0);
        chk({tag, "_ends_left"}, 64'(pq.size()), 0);
        nq.delete();
        pq.delete();
    endtask

    // Output monitor: every note_valid / phrase_end must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.note_valid) begin
                if (nq.size() == 0) begin
                    chk("note_valid_unexpected", 64'(bus.note_valid), 0);
                end else begin
                    ev_t e;
                    e = nq.pop_front();
                    chk("note_cycle", 64'(cyc), 64'(e.cyc));
                    chk("note_words", {bus.ch3_q, bus.ch2_q, bus.ch1_q, bus.ch0_q}, e.w);
                    chk("note_trig", 64'(bus.ch_trig), 64'(e.trig));
                end
            end else begin
                chk("trig_without_valid", 64'(bus.ch_trig), 0);
            end
            if (bus.phrase_end) begin
                if (pq.size() == 0) begin
                    chk("phrase_end_unexpected", 64'(bus.phrase_end), 0);
                end else begin
                    chk("phrase_end_cycle", 64'(cyc), 64'(pq.pop_front()));
                end
            end
        end
    end

    initial begin
        int p, p2, q;
        rst               = 1'b1;
        bus.play          = 1'b0;
        bus.stop          = 1'b0;
        bus.loop_en       = 1'b0;
        bus.start_row     = '0;
        bus.tick_period   = '0;
        bus.ticks_per_row = '0;
        bus.mute          = '0;
        repeat (3) @(negedge clk);
        chk("rst_row", 64'(bus.row), 0);
        chk("rst_playing", 64'(bus.playing), 0);
        chk("rst_note_valid", 64'(bus.note_valid), 0);
        chk("rst_phrase_end", 64'(bus.phrase_end), 0);
        chk("rst_words", {bus.ch3_q, bus.ch2_q, bus.ch1_q, bus.ch0_q}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // One-shot phrase: 8 clocks per row, 16 notes, then idle at row 15.
        start_play(4'd0, 4, 2, 1'b0, p);
        for (int j = 0; j < 16; j++) push_note(p + 2 + 8 * j, j);
        pq.push_back(p + 129);
        chk("p1_row_start", 64'(bus.row), 0);
        chk("p1_playing", 64'(bus.playing), 1);
        wait_until(p + 8);
        chk("p1_row_hold", 64'(bus.row), 0);
        wait_until(p + 9);
        chk("p1_row_step", 64'(bus.row), 1);
        wait_until(p + 128);
        chk("p1_row_last", 64'(bus.row), 15);
        chk("p1_playing_last", 64'(bus.playing), 1);
        wait_until(p + 129);
        chk("p1_stopped", 64'(bus.playing), 0);
        wait_until(p + 140);
        chk("p1_row_held", 64'(bus.row), 15);
        drain("p1");

        // Looping phrase, stopped exactly in a fetch cycle.
        start_play(4'd0, 4, 2, 1'b1, p);
        for (int j = 0; j < 17; j++) push_note(p + 2 + 8 * j, j % 16);
        pq.push_back(p + 129);
        wait_until(p + 129);
        chk("p2_wrap_row", 64'(bus.row), 0);
        chk("p2_wrap_playing", 64'(bus.playing), 1);
        wait_until(p + 137);
        chk("p2_row_before_stop", 64'(bus.row), 1);
        pulse_stop();
        chk("p2_stop_playing", 64'(bus.playing), 0);
        wait_until(p + 150);
        chk("p2_row_frozen", 64'(bus.row), 1);
        drain("p2");

        // Rest and mute on row 5.
        bus.mute = 4'b0100;
        start_play(4'd5, 4, 2, 1'b0, p);
        push_note(p + 2, 5);
        wait_until(p + 2);
        chk("rest_trig", 64'(bus.ch_trig), 64'(4'b1001));
        wait_until(p + 5);
        pulse_stop();
        wait_until(p + 15);
        bus.mute = 4'b0000;
        drain("rest");

        // Simultaneous play and stop while idle: nothing happens.
        q             = cyc;
        bus.start_row = 4'd9;
        bus.play      = 1'b1;
        bus.stop      = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
        bus.stop = 1'b0;
        chk("ps_playing", 64'(bus.playing), 0);
        chk("ps_row", 64'(bus.row), 5);
        wait_until(q + 6);
        drain("ps");

        // Restart from row 3 while playing row 9.
        start_play(4'd0, 4, 2, 1'b0, p);
        for (int j = 0; j < 10; j++) push_note(p + 2 + 8 * j, j);
        wait_until(p + 75);
        chk("rs_row9", 64'(bus.row), 9);
        start_play(4'd3, 4, 2, 1'b0, p2);
        push_note(p2 + 2, 3);
        push_note(p2 + 10, 4);
        chk("rs_row3", 64'(bus.row), 3);
        chk("rs_playing", 64'(bus.playing), 1);
        wait_until(p2 + 8);
        chk("rs_row3_hold", 64'(bus.row), 3);
        wait_until(p2 + 9);
        chk("rs_row4", 64'(bus.row), 4);
        wait_until(p2 + 12);
        pulse_stop();
        wait_until(p2 + 20);
        chk("rs_row_frozen", 64'(bus.row), 4);
        drain("rs");

        // Zero period and speed: one row per clock.
        start_play(4'd2, 0, 0, 1'b0, p);
        for (int r = 2; r < 16; r++) push_note(p + r, r);
        pq.push_back(p + 15);
        chk("fast_row_start", 64'(bus.row), 2);
        wait_until(p + 5);
        chk("fast_row6", 64'(bus.row), 6);
        wait_until(p + 14);
        chk("fast_row15", 64'(bus.row), 15);
        wait_until(p + 16);
        chk("fast_done", 64'(bus.playing), 0);
        wait_until(p + 24);
        drain("fast");

        // Period lowered 100 -> 2 at tick_cnt 50: tick in that cycle.
        start_play(4'd0, 100, 1, 1'b0, p);
        push_note(p + 2, 0);
        push_note(p + 53, 1);
        wait_until(p + 51);
        chk("tp_row_before", 64'(bus.row), 0);
        bus.tick_period = 24'd2;
        @(negedge clk);
        chk("tp_row_after", 64'(bus.row), 1);
        wait_until(p + 53);
        pulse_stop();
        wait_until(p + 60);
        chk("tp_row_frozen", 64'(bus.row), 1);
        drain("tp");

        // Asynchronous reset mid-row.
        start_play(4'd0, 4, 2, 1'b0, p);
        push_note(p + 2, 0);
        push_note(p + 10, 1);
        push_note(p + 18, 2);
        wait_until(p + 20);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_row", 64'(bus.row), 0);
        chk("ar_playing", 64'(bus.playing), 0);
        chk("ar_words", {bus.ch3_q, bus.ch2_q, bus.ch1_q, bus.ch0_q}, 0);
        chk("ar_note_valid", 64'(bus.note_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q = cyc;
        wait_until(q + 40);
        chk("ar_idle", 64'(bus.playing), 0);
        drain("ar");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
